regfile_wb_scheduler: RTL and testbench

//  Shares the register file's single write port between the ALU and memory writeback paths.

---
 rtl/regfile_wb_scheduler.sv | 124 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Writeback arbiter for a single register-file write port shared by ALU and load paths,
// with a pending-write scoreboard that stalls issue on RAW/WAW hazards and a PC-redirect port.
module regfile_wb_scheduler #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int PC_IDX = 15
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   alu_valid_i,
   output logic                   alu_ready_o,
   input  logic [ADDR_W-1:0]      alu_addr_i,
   input  logic [DATA_W-1:0]      alu_data_i,
   input  logic                   mem_valid_i,
   output logic                   mem_ready_o,
   input  logic [ADDR_W-1:0]      mem_addr_i,
   input  logic [DATA_W-1:0]      mem_data_i,
   input  logic                   claim_i,
   input  logic [ADDR_W-1:0]      claim_addr_i,
   input  logic                   rs1_en_i,
   input  logic [ADDR_W-1:0]      rs1_addr_i,
   input  logic                   rs2_en_i,
   input  logic [ADDR_W-1:0]      rs2_addr_i,
   output logic                   stall_o,
   output logic                   rf_wr_en_o,
   output logic [ADDR_W-1:0]      rf_wr_addr_o,
   output logic [DATA_W-1:0]      rf_data_o,
   output logic                   pc_wr_en_o,
   output logic [DATA_W-1:0]      pc_data_o,
   output logic [(2**ADDR_W)-1:0] busy_o,
   output logic                   spurious_o
);

   localparam int NREG = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

   // Handshake: a writeback moves on an edge where valid & ready are both high;
   // a requester seeing ready=0 keeps valid, addr and data stable until accepted.
   logic                r_prio;          // 0: ALU holds priority, 1: load path holds priority
   logic [NREG-1:0]     r_busy;
   logic                r_rf_wr_en;
   logic [ADDR_W-1:0]   r_rf_wr_addr;
   logic [DATA_W-1:0]   r_rf_data;
   logic                r_pc_wr_en;
   logic [DATA_W-1:0]   r_pc_data;
   logic                r_spurious;

   logic                w_alu_xfer;
   logic                w_mem_xfer;
   logic                w_xfer;
   logic                w_contest;
   logic [ADDR_W-1:0]   w_wb_addr;
   logic [DATA_W-1:0]   w_wb_data;
   logic                w_wb_is_pc;
   logic                w_stall;
   logic [NREG-1:0]     w_set;
   logic [NREG-1:0]     w_clr;
   logic [NREG-1:0]     w_busy_nxt;

   always_comb begin
      alu_ready_o = alu_valid_i & (~mem_valid_i | ~r_prio);
      mem_ready_o = mem_valid_i & (~alu_valid_i | r_prio);
      w_alu_xfer  = alu_ready_o;
      w_mem_xfer  = mem_ready_o;
      w_xfer      = w_alu_xfer | w_mem_xfer;
      w_contest   = alu_valid_i & mem_valid_i;
      w_wb_addr   = w_alu_xfer ? alu_addr_i : mem_addr_i;
      w_wb_data   = w_alu_xfer ? alu_data_i : mem_data_i;
      w_wb_is_pc  = (w_wb_addr == PC_ADDR);
   end

   // The claim term is the WAW check against a destination already in flight.
   always_comb begin
      w_stall = (rs1_en_i & r_busy[rs1_addr_i])
              | (rs2_en_i & r_busy[rs2_addr_i])
              | (claim_i  & r_busy[claim_addr_i]);
   end

   // Set is applied after clear so a same-edge claim of a retiring register stays busy.
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (claim_i && !w_stall) w_set[claim_addr_i] = 1'b1;
      if (r_rf_wr_en)          w_clr[r_rf_wr_addr] = 1'b1;
      if (r_pc_wr_en)          w_clr[PC_ADDR]      = 1'b1;
      w_busy_nxt = (r_busy & ~w_clr) | w_set;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_prio       <= 1'b0;
         r_busy       <= '0;
         r_rf_wr_en   <= 1'b0;
         r_rf_wr_addr <= '0;
         r_rf_data    <= '0;
         r_pc_wr_en   <= 1'b0;
         r_pc_data    <= '0;
         r_spurious   <= 1'b0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_rf_wr_en <= w_xfer & ~w_wb_is_pc;
         r_pc_wr_en <= w_xfer & w_wb_is_pc;
         r_spurious <= w_xfer & ~r_busy[w_wb_addr];
         if (w_contest) r_prio <= w_alu_xfer;
         if (w_xfer && !w_wb_is_pc) begin
            r_rf_wr_addr <= w_wb_addr;
            r_rf_data    <= w_wb_data;
         end
         if (w_xfer && w_wb_is_pc) r_pc_data <= w_wb_data;
      end
   end

   always_comb begin
      stall_o      = w_stall;
      rf_wr_en_o   = r_rf_wr_en;
      rf_wr_addr_o = r_rf_wr_addr;
      rf_data_o    = r_rf_data;
      pc_wr_en_o   = r_pc_wr_en;
      pc_data_o    = r_pc_data;
      busy_o       = r_busy;
      spurious_o   = r_spurious;
   end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios with literal checks, then random
// traffic compared every cycle against a queue/array model of the writeback rules.
module tb_regfile_wb_scheduler;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int NR = 16;
   localparam int PC = 15;
   localparam int QW = 1 + AW + DW;

   logic          clk;
   logic          rst_n;
   logic          alu_valid, mem_valid, claim, rs1_en, rs2_en;
   logic [AW-1:0] alu_addr, mem_addr, claim_addr, rs1_addr, rs2_addr;
   logic [DW-1:0] alu_data, mem_data;
   logic          alu_ready, mem_ready, stall, rf_wr_en, pc_wr_en, spurious;
   logic [AW-1:0] rf_wr_addr;
   logic [DW-1:0] rf_data, pc_data;
   logic [NR-1:0] busy;

   regfile_wb_scheduler #(.DATA_W(DW), .ADDR_W(AW), .PC_IDX(PC)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_addr_i(alu_addr), .alu_data_i(alu_data),
      .mem_valid_i(mem_valid), .mem_ready_o(mem_ready), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
      .claim_i(claim), .claim_addr_i(claim_addr),
      .rs1_en_i(rs1_en), .rs1_addr_i(rs1_addr), .rs2_en_i(rs2_en), .rs2_addr_i(rs2_addr),
      .stall_o(stall), .rf_wr_en_o(rf_wr_en), .rf_wr_addr_o(rf_wr_addr), .rf_data_o(rf_data),
      .pc_wr_en_o(pc_wr_en), .pc_data_o(pc_data), .busy_o(busy), .spurious_o(spurious)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Model state: who won the last contest, pending destinations, expected write stream
   bit            m_mem_has_prio;
   bit [NR-1:0]   m_busy;
   logic [QW-1:0] exp_q[$];
   bit            m_rf_en, m_pc_en, m_spur;
   logic [AW-1:0] m_rf_addr;
   logic [DW-1:0] m_rf_data, m_pc_data;
   bit            e_ar, e_mr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mem_has_prio = 1'b0;
      m_busy = '0;
      exp_q.delete();
      m_rf_en = 0; m_pc_en = 0; m_spur = 0;
      m_rf_addr = '0; m_rf_data = '0; m_pc_data = '0;
      e_ar = 0; e_mr = 0;
   endtask

   task automatic idle();
      alu_valid = 0; mem_valid = 0; claim = 0; rs1_en = 0; rs2_en = 0;
      alu_addr = '0; mem_addr = '0; claim_addr = '0; rs1_addr = '0; rs2_addr = '0;
      alu_data = '0; mem_data = '0;
   endtask

   function automatic bit m_stall();
      return (rs1_en && m_busy[rs1_addr]) || (rs2_en && m_busy[rs2_addr]) || (claim && m_busy[claim_addr]);
   endfunction

   // One clock: called at a negedge with inputs already driven; returns at the next negedge.
   task automatic step();
      bit [NR-1:0]   nb;
      bit            s;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [QW-1:0] w;
      #1;
      if (alu_valid && mem_valid) begin
         e_ar = !m_mem_has_prio;
         e_mr = m_mem_has_prio;
      end else begin
         e_ar = alu_valid;
         e_mr = mem_valid;
      end
      chk("alu_ready", alu_ready, e_ar);
      chk("mem_ready", mem_ready, e_mr);
      chk("stall", stall, m_stall());
      @(posedge clk);
      nb = m_busy;
      if (m_rf_en) nb[m_rf_addr] = 0;
      if (m_pc_en) nb[PC] = 0;
      if (claim && !m_stall()) nb[claim_addr] = 1;
      s = 0;
      if (e_ar || e_mr) begin
         a = e_ar ? alu_addr : mem_addr;
         d = e_ar ? alu_data : mem_data;
         exp_q.push_back({(int'(a) == PC), a, d});
         s = !m_busy[a];
      end
      if (alu_valid && mem_valid) m_mem_has_prio = e_ar;
      m_busy = nb;
      m_spur = s;
      @(negedge clk);
      m_rf_en = 0;
      m_pc_en = 0;
      if (exp_q.size() > 0) begin
         w = exp_q.pop_front();
         if (w[QW-1]) begin
            m_pc_en = 1; m_pc_data = w[DW-1:0];
         end else begin
            m_rf_en = 1; m_rf_addr = w[DW+AW-1:DW]; m_rf_data = w[DW-1:0];
         end
      end
      chk("rf_wr_en", rf_wr_en, m_rf_en);
      chk("rf_wr_addr", rf_wr_addr, m_rf_addr);
      chk("rf_data", rf_data, m_rf_data);
      chk("pc_wr_en", pc_wr_en, m_pc_en);
      chk("pc_data", pc_data, m_pc_data);
      chk("busy", busy, m_busy);
      chk("spurious", spurious, m_spur);
   endtask

   function automatic logic [AW-1:0] pick_addr();
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, NR-1));
      if (m_busy != 0 && $urandom_range(0, 99) < 80) begin
         for (int k = 0; k < 64; k++) begin
            if (m_busy[a]) break;
            a = AW'($urandom_range(0, NR-1));
         end
      end
      return a;
   endfunction

   task automatic drive_rand();
      if (!(alu_valid && !e_ar)) begin
         alu_valid = ($urandom_range(0, 99) < 55);
         alu_addr  = pick_addr();
         alu_data  = $urandom;
      end
      if (!(mem_valid && !e_mr)) begin
         mem_valid = ($urandom_range(0, 99) < 55);
         mem_addr  = pick_addr();
         mem_data  = $urandom;
      end
      claim      = ($urandom_range(0, 99) < 40);
      claim_addr = AW'($urandom_range(0, NR-1));
      rs1_en     = ($urandom_range(0, 1) == 1);
      rs1_addr   = AW'($urandom_range(0, NR-1));
      rs2_en     = ($urandom_range(0, 1) == 1);
      rs2_addr   = AW'($urandom_range(0, NR-1));
   endtask

   initial begin
      rst_n = 0;
      idle();
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst rf_wr_en", rf_wr_en, 0);
      chk("rst pc_wr_en", pc_wr_en, 0);
      chk("rst busy", busy, 0);
      chk("rst spurious", spurious, 0);
      rst_n = 1;

      // Claim r3, ALU writes r3=0x11
      claim = 1; claim_addr = 3; step();
      chk("t1 busy3 set", busy[3], 1);
      idle(); alu_valid = 1; alu_addr = 3; alu_data = 32'h11; step();
      chk("t1 wr_en", rf_wr_en, 1);
      chk("t1 wr_addr", rf_wr_addr, 3);
      chk("t1 wr_data", rf_data, 32'h11);
      chk("t1 spurious", spurious, 0);
      idle(); step();
      chk("t1 busy3 clear", busy[3], 0);

      // Contention on r4 (ALU) and r5 (mem)
      claim = 1; claim_addr = 4; step();
      claim_addr = 5; step();
      idle();
      alu_valid = 1; alu_addr = 4; alu_data = 32'hA4;
      mem_valid = 1; mem_addr = 5; mem_data = 32'hB5;
      #1;
      chk("t2 alu first", alu_ready, 1);
      chk("t2 mem waits", mem_ready, 0);
      step();
      alu_addr = 4; alu_data = 32'hC4;
      #1;
      chk("t2 mem second", mem_ready, 1);
      chk("t2 alu waits", alu_ready, 0);
      step();
      chk("t2 wr mem r5", rf_wr_addr, 5);
      mem_valid = 0; step();
      idle(); step();

      // RAW stall on r6 held through its write cycle
      claim = 1; claim_addr = 6; step();
      idle(); rs1_en = 1; rs1_addr = 6;
      #1 chk("t3 stall pending", stall, 1);
      alu_valid = 1; alu_addr = 6; alu_data = 32'h66; step();
      alu_valid = 0;
      #1 chk("t3 stall in wr cycle", stall, 1);
      step();
      #1 chk("t3 stall dropped", stall, 0);
      step();

      // r15 goes to PC redirect
      idle(); claim = 1; claim_addr = 15; step();
      idle(); mem_valid = 1; mem_addr = 15; mem_data = 32'h100; step();
      chk("t4 pc_wr_en", pc_wr_en, 1);
      chk("t4 pc_data", pc_data, 32'h100);
      chk("t4 rf_wr_en", rf_wr_en, 0);
      idle(); step();
      chk("t4 busy15 clear", busy[15], 0);

      // Spurious write to r7; same-edge set/clear of r2
      alu_valid = 1; alu_addr = 7; alu_data = 32'h77; step();
      chk("t5 spurious", spurious, 1);
      chk("t5 wr r7", rf_wr_addr, 7);
      idle(); alu_valid = 1; alu_addr = 2; alu_data = 32'h22; step();
      chk("t5 spurious once", spurious, 1);
      idle(); claim = 1; claim_addr = 2; step();
      chk("t5 busy2 kept", busy[2], 1);
      idle(); step();

      // Async reset while a write is in flight
      alu_valid = 1; alu_addr = 9; alu_data = 32'h99;
      mem_valid = 1; mem_addr = 10; mem_data = 32'hAA;
      #1;
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("t6 rf_wr_en", rf_wr_en, 0);
      chk("t6 busy", busy, 0);
      chk("t6 rf_data", rf_data, 0);
      chk("t6 pc_data", pc_data, 0);
      @(negedge clk);
      rst_n = 1;
      model_reset();
      #1 chk("t6 alu prio", alu_ready, 1);
      step();
      idle(); step();

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         drive_rand();
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
